// File: rtl/ofs_plat_host_chan_intr_engine.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_host_chan_intr_engine
// Purpose  : Multi-vector interrupt request engine. CSR writes raise vectors
//            into a pending set. Pending vectors are issued one at a time,
//            selected round-robin, on a valid/ready request port. Host
//            responses retire them from the outstanding set.
// Optional : `define OFS_PLAT_HOST_CHAN_INTR_TIMEOUT_EN to build the
//            outstanding-request watchdog. Without it err_timeout is tied 0.
// Ports    : clk, reset                  - clock, synchronous active-high reset
//            trig_valid, trig_mask       - CSR trigger strobe and vector mask
//            status_clr                  - clears counters and sticky flags
//            intr_req_valid/ready/id     - request handshake to host channel
//            intr_rsp_valid/id           - response strobe from host channel
//            pending, outstanding        - per-vector state
//            rsp_count, coalesce_count   - retired responses, merged triggers
//            err_unexpected_rsp          - sticky bad-response flag
//            err_timeout                 - sticky watchdog flag
// Revision : 1.0 - initial release
// ============================================================================
module ofs_plat_host_chan_intr_engine #(
  parameter int NUM_INTR_IDS    = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int COUNT_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES  = 65535,
  localparam int IDW = (NUM_INTR_IDS > 1) ? $clog2(NUM_INTR_IDS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trig_valid,
  input  logic [NUM_INTR_IDS-1:0] trig_mask,
  input  logic                    status_clr,
  output logic                    intr_req_valid,
  input  logic                    intr_req_ready,
  output logic [IDW-1:0]          intr_req_id,
  input  logic                    intr_rsp_valid,
  input  logic [IDW-1:0]          intr_rsp_id,
  output logic [NUM_INTR_IDS-1:0] pending,
  output logic [NUM_INTR_IDS-1:0] outstanding,
  output logic [COUNT_WIDTH-1:0]  rsp_count,
  output logic [COUNT_WIDTH-1:0]  coalesce_count,
  output logic                    err_unexpected_rsp,
  output logic                    err_timeout
);

  localparam int             OCW         = $clog2(NUM_INTR_IDS + 1);
  localparam logic [IDW:0]   NUM_IDS_EXT = (IDW + 1)'(NUM_INTR_IDS);
  localparam logic [IDW-1:0] LAST_ID     = IDW'(NUM_INTR_IDS - 1);
  localparam logic [OCW-1:0] MAX_OUT_C   = OCW'(MAX_OUTSTANDING);

  if (NUM_INTR_IDS < 1 || NUM_INTR_IDS > 64 || MAX_OUTSTANDING < 1 ||
      MAX_OUTSTANDING > NUM_INTR_IDS || COUNT_WIDTH < 1 || TIMEOUT_CYCLES < 1)
  begin : g_bad_params
    $error("ofs_plat_host_chan_intr_engine: parameter out of range");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    req_valid_q;
  logic [IDW-1:0]          req_id_q;
  logic [IDW-1:0]          rr_q;

  logic [NUM_INTR_IDS-1:0] pending_q,     pending_d;
  logic [NUM_INTR_IDS-1:0] outstanding_q, outstanding_d;
  logic [OCW-1:0]          out_cnt_q,     out_cnt_d;
  logic [COUNT_WIDTH-1:0]  rsp_count_q,   rsp_count_d;
  logic [COUNT_WIDTH-1:0]  coal_count_q,  coal_count_d;
  logic                    err_rsp_q,     err_rsp_d;

  logic                    hs;
  logic [NUM_INTR_IDS-1:0] hs_oh;
  logic [NUM_INTR_IDS-1:0] rsp_oh;
  logic                    rsp_in_range;
  logic                    rsp_ok;
  logic                    rsp_bad;
  logic                    coalesce;
  logic [NUM_INTR_IDS-1:0] eligible;
  logic                    issue_gate;
  logic                    sel_found;
  logic [IDW-1:0]          sel_id;
  logic [IDW:0]            cand;

  // Ids at or beyond NUM_INTR_IDS shift out of the vector and yield zero.
  function automatic logic [NUM_INTR_IDS-1:0] id_onehot(input logic [IDW-1:0] id);
    return NUM_INTR_IDS'(1) << id;
  endfunction

  assign hs           = req_valid_q & intr_req_ready;
  assign hs_oh        = hs ? id_onehot(req_id_q) : '0;
  assign rsp_oh       = id_onehot(intr_rsp_id);
  assign rsp_in_range = ({1'b0, intr_rsp_id} < NUM_IDS_EXT);
  // A handshaking id is not yet outstanding, so a response to it lands here
  // as unexpected rather than racing the set.
  assign rsp_ok       = intr_rsp_valid & rsp_in_range & (|(outstanding_q & rsp_oh));
  assign rsp_bad      = intr_rsp_valid & ~rsp_ok;
  assign coalesce     = trig_valid & (|(trig_mask & pending_q));
  assign eligible     = pending_q & ~outstanding_q;
  assign issue_gate   = (out_cnt_q < MAX_OUT_C);

  // Round-robin pick: first eligible id at or after rr_q, wrapping at
  // NUM_INTR_IDS (which need not be a power of two).
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_INTR_IDS; i++) begin
      cand = {1'b0, rr_q} + (IDW + 1)'(i);
      if (cand >= NUM_IDS_EXT) begin
        cand = cand - NUM_IDS_EXT;
      end
      if (!sel_found && (|(eligible & id_onehot(cand[IDW-1:0])))) begin
        sel_found = 1'b1;
        sel_id    = cand[IDW-1:0];
      end
    end
  end

  // Request FSM. The request registers in IDLE and is held through REQ, so a
  // new trigger on the same vector never disturbs a request already offered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      req_id_q    <= '0;
      rr_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found && issue_gate) begin
            req_id_q    <= sel_id;
            req_valid_q <= 1'b1;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (intr_req_ready) begin
            req_valid_q <= 1'b0;
            rr_q        <= (req_id_q == LAST_ID) ? '0 : req_id_q + IDW'(1);
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          req_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    // Trigger is applied after the handshake clear so a same-cycle re-trigger
    // leaves the vector pending for a later re-issue.
    pending_d     = (pending_q & ~hs_oh) | (trig_valid ? trig_mask : '0);
    outstanding_d = (outstanding_q & ~(rsp_ok ? rsp_oh : '0)) | hs_oh;

    out_cnt_d = out_cnt_q;
    if (hs && !rsp_ok) begin
      out_cnt_d = out_cnt_q + OCW'(1);
    end else if (!hs && rsp_ok) begin
      out_cnt_d = out_cnt_q - OCW'(1);
    end

    rsp_count_d  = status_clr ? '0 : rsp_count_q  + COUNT_WIDTH'(rsp_ok);
    coal_count_d = status_clr ? '0 : coal_count_q + COUNT_WIDTH'(coalesce);
    err_rsp_d    = status_clr ? 1'b0 : (err_rsp_q | rsp_bad);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      out_cnt_q     <= '0;
      rsp_count_q   <= '0;
      coal_count_q  <= '0;
      err_rsp_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      out_cnt_q     <= out_cnt_d;
      rsp_count_q   <= rsp_count_d;
      coal_count_q  <= coal_count_d;
      err_rsp_q     <= err_rsp_d;
    end
  end

`ifdef OFS_PLAT_HOST_CHAN_INTR_TIMEOUT_EN
  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] wd_q;
  logic          err_to_q;

  // Watchdog restarts whenever the engine is quiet or a response retires,
  // and saturates at the limit so the sticky flag keeps re-asserting.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q     <= '0;
      err_to_q <= 1'b0;
    end else begin
      if ((outstanding_q == '0) || rsp_ok) begin
        wd_q <= '0;
      end else if (wd_q != TIMEOUT_C) begin
        wd_q <= wd_q + TW'(1);
      end

      if (status_clr) begin
        err_to_q <= 1'b0;
      end else if (wd_q == TIMEOUT_C) begin
        err_to_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign intr_req_valid     = req_valid_q;
  assign intr_req_id        = req_id_q;
  assign pending            = pending_q;
  assign outstanding        = outstanding_q;
  assign rsp_count          = rsp_count_q;
  assign coalesce_count     = coal_count_q;
  assign err_unexpected_rsp = err_rsp_q;

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_host_chan_intr_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofs_plat_host_chan_intr_engine
// Purpose  : Self-checking bench. Two engines share one stimulus stream:
//            instance 0 has 4 vectors and up to 4 in flight, instance 1 has
//            5 vectors (3-bit ids, so out-of-range ids exist) and up to 2 in
//            flight. A per-cycle behavioural model built from sets and
//            round-robin search supplies every expected value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofs_plat_host_chan_intr_engine;

  localparam int TMO = 16;
  localparam int NN[2] = '{4, 5};
  localparam int MM[2] = '{4, 2};

  logic       clk;
  logic       reset;
  logic       trig_valid;
  logic [4:0] trig_mask;
  logic       status_clr;
  logic       intr_req_ready;
  logic       intr_rsp_valid;
  logic [2:0] rsp_id;

  logic        a_valid, a_err, a_to;
  logic [1:0]  a_id;
  logic [3:0]  a_pend, a_outs;
  logic [31:0] a_rspc, a_coal;
  logic        b_valid, b_err, b_to;
  logic [2:0]  b_id;
  logic [4:0]  b_pend, b_outs;
  logic [31:0] b_rspc, b_coal;

  logic        o_valid[2];
  logic [2:0]  o_id[2];
  logic [4:0]  o_pend[2];
  logic [4:0]  o_outs[2];
  logic [31:0] o_rspc[2];
  logic [31:0] o_coal[2];
  logic        o_err[2];
  logic        o_to[2];

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cyc      = 0;

  // Reference model state (bit sets held in ints).
  int        m_pend[2];
  int        m_outs[2];
  int        m_busy[2];
  int        m_rid[2];
  int        m_rr[2];
  int        m_wd[2];
  bit [31:0] m_rspc[2];
  bit [31:0] m_coal[2];
  bit        m_err[2];
  bit        m_to[2];

  ofs_plat_host_chan_intr_engine #(
    .NUM_INTR_IDS(4), .MAX_OUTSTANDING(4), .COUNT_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) u_dut_a (
    .clk(clk), .reset(reset), .trig_valid(trig_valid), .trig_mask(trig_mask[3:0]),
    .status_clr(status_clr), .intr_req_valid(a_valid), .intr_req_ready(intr_req_ready),
    .intr_req_id(a_id), .intr_rsp_valid(intr_rsp_valid), .intr_rsp_id(rsp_id[1:0]),
    .pending(a_pend), .outstanding(a_outs), .rsp_count(a_rspc), .coalesce_count(a_coal),
    .err_unexpected_rsp(a_err), .err_timeout(a_to)
  );

  ofs_plat_host_chan_intr_engine #(
    .NUM_INTR_IDS(5), .MAX_OUTSTANDING(2), .COUNT_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) u_dut_b (
    .clk(clk), .reset(reset), .trig_valid(trig_valid), .trig_mask(trig_mask),
    .status_clr(status_clr), .intr_req_valid(b_valid), .intr_req_ready(intr_req_ready),
    .intr_req_id(b_id), .intr_rsp_valid(intr_rsp_valid), .intr_rsp_id(rsp_id),
    .pending(b_pend), .outstanding(b_outs), .rsp_count(b_rspc), .coalesce_count(b_coal),
    .err_unexpected_rsp(b_err), .err_timeout(b_to)
  );

  assign o_valid[0] = a_valid;  assign o_valid[1] = b_valid;
  assign o_id[0]    = {1'b0, a_id}; assign o_id[1] = b_id;
  assign o_pend[0]  = {1'b0, a_pend}; assign o_pend[1] = b_pend;
  assign o_outs[0]  = {1'b0, a_outs}; assign o_outs[1] = b_outs;
  assign o_rspc[0]  = a_rspc;   assign o_rspc[1]  = b_rspc;
  assign o_coal[0]  = a_coal;   assign o_coal[1]  = b_coal;
  assign o_err[0]   = a_err;    assign o_err[1]   = b_err;
  assign o_to[0]    = a_to;     assign o_to[1]    = b_to;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock: derive the model's next state from the current inputs,
  // then commit it 1 time unit after the edge where outputs are sampled.
  task automatic tick();
    int n, tm, rin, hs, rok, elig, j, found;
    int p_n[2], o_n[2], b_n[2], id_n[2], rr_n[2], wd_n[2];
    bit [31:0] rc_n[2], cc_n[2];
    bit e_n[2], t_n[2];
    for (int k = 0; k < 2; k++) begin
      n    = NN[k];
      tm   = int'(trig_mask) & ((1 << n) - 1);
      rin  = (k == 0) ? (int'(rsp_id) & 3) : int'(rsp_id);
      hs   = (m_busy[k] != 0 && intr_req_ready) ? 1 : 0;
      rok  = (intr_rsp_valid && rin < n && ((m_outs[k] >> rin) & 1) == 1) ? 1 : 0;
      p_n[k] = (m_pend[k] & ~(hs != 0 ? (1 << m_rid[k]) : 0)) | (trig_valid ? tm : 0);
      o_n[k] = (m_outs[k] & ~(rok != 0 ? (1 << rin) : 0)) | (hs != 0 ? (1 << m_rid[k]) : 0);
      b_n[k] = m_busy[k]; id_n[k] = m_rid[k]; rr_n[k] = m_rr[k];
      if (m_busy[k] == 0) begin
        elig  = m_pend[k] & ~m_outs[k];
        found = 0;
        if (elig != 0 && $countones(m_outs[k]) < MM[k]) begin
          for (int i = 0; i < n; i++) begin
            j = (m_rr[k] + i) % n;
            if (found == 0 && ((elig >> j) & 1) == 1) begin
              found = 1; id_n[k] = j; b_n[k] = 1;
            end
          end
        end
      end else if (hs != 0) begin
        b_n[k]  = 0;
        rr_n[k] = (m_rid[k] + 1) % n;
      end
      cc_n[k] = status_clr ? 32'd0 : m_coal[k] + ((trig_valid && (tm & m_pend[k]) != 0) ? 32'd1 : 32'd0);
      rc_n[k] = status_clr ? 32'd0 : m_rspc[k] + 32'(rok);
      e_n[k]  = status_clr ? 1'b0 : (m_err[k] | (intr_rsp_valid && rok == 0));
      t_n[k]  = m_to[k];
      wd_n[k] = m_wd[k];
`ifdef OFS_PLAT_HOST_CHAN_INTR_TIMEOUT_EN
      t_n[k]  = status_clr ? 1'b0 : ((m_wd[k] == TMO) ? 1'b1 : m_to[k]);
      wd_n[k] = (m_outs[k] == 0 || rok != 0) ? 0 : ((m_wd[k] == TMO) ? TMO : m_wd[k] + 1);
`endif
      if (reset) begin
        p_n[k] = 0; o_n[k] = 0; b_n[k] = 0; id_n[k] = 0; rr_n[k] = 0; wd_n[k] = 0;
        rc_n[k] = 0; cc_n[k] = 0; e_n[k] = 0; t_n[k] = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = p_n[k]; m_outs[k] = o_n[k]; m_busy[k] = b_n[k]; m_rid[k] = id_n[k];
      m_rr[k] = rr_n[k]; m_wd[k] = wd_n[k]; m_rspc[k] = rc_n[k]; m_coal[k] = cc_n[k];
      m_err[k] = e_n[k]; m_to[k] = t_n[k];
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; trig_valid = 1'b0; trig_mask = '0; status_clr = 1'b0;
    intr_req_ready = 1'b0; intr_rsp_valid = 1'b0; rsp_id = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      vec_cnt++;
      if ({o_valid[k], o_id[k], o_pend[k], o_outs[k], o_rspc[k], o_coal[k], o_err[k], o_to[k]} !== '0) begin
        miss_cnt++;
        $display("FAIL reset_state inst%0d: got valid=%b id=%0d pend=%b outs=%b rspc=%0d coal=%0d err=%b to=%b, expected all zero",
                 k, o_valid[k], o_id[k], o_pend[k], o_outs[k], o_rspc[k], o_coal[k], o_err[k], o_to[k]);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    trig_valid = 1'b1; trig_mask = 5'b00001; intr_req_ready = 1'b1;
    tick();
    trig_valid = 1'b0;
    vec_cnt++;
    if (o_pend[0] !== 5'b00001 || o_valid[0] !== 1'b0) begin
      miss_cnt++;
      $display("FAIL single_pending: got pend=%b valid=%b, expected pend=00001 valid=0", o_pend[0], o_valid[0]);
    end
    tick();
    vec_cnt++;
    if (o_valid[0] !== 1'b1 || o_id[0] !== 3'd0) begin
      miss_cnt++;
      $display("FAIL single_req: got valid=%b id=%0d, expected valid=1 id=0", o_valid[0], o_id[0]);
    end
    tick();
    vec_cnt++;
    if (o_outs[0] !== 5'b00001 || o_pend[0] !== 5'b00000 || o_valid[0] !== 1'b0) begin
      miss_cnt++;
      $display("FAIL single_handshake: got outs=%b pend=%b valid=%b, expected outs=00001 pend=0 valid=0",
               o_outs[0], o_pend[0], o_valid[0]);
    end
    intr_rsp_valid = 1'b1; rsp_id = 3'd0;
    tick();
    intr_rsp_valid = 1'b0;
    vec_cnt++;
    if (o_outs[0] !== 5'b00000 || o_rspc[0] !== 32'd1) begin
      miss_cnt++;
      $display("FAIL single_response: got outs=%b rspc=%0d, expected outs=0 rspc=1", o_outs[0], o_rspc[0]);
    end
  endtask

  task automatic test_in_order();
    int due[$];
    int did[$];
    int order[$];
    apply_reset();
    trig_valid = 1'b1; trig_mask = 5'b01111; intr_req_ready = 1'b1;
    tick();
    trig_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      intr_rsp_valid = 1'b0;
      if (due.size() > 0 && due[0] == cyc) begin
        intr_rsp_valid = 1'b1;
        rsp_id = 3'(did[0]);
        void'(due.pop_front());
        void'(did.pop_front());
      end
      if (a_valid && intr_req_ready) begin
        order.push_back(int'(a_id));
        due.push_back(cyc + 2);
        did.push_back(int'(a_id));
      end
      tick();
    end
    intr_rsp_valid = 1'b0;
    vec_cnt++;
    if (order.size() != 4) begin
      miss_cnt++;
      $display("FAIL in_order_count: got %0d requests, expected 4", order.size());
    end
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      vec_cnt++;
      if (order[i] != i) begin
        miss_cnt++;
        $display("FAIL in_order_id[%0d]: got id=%0d, expected %0d", i, order[i], i);
      end
    end
    vec_cnt++;
    if (o_rspc[0] !== 32'd4 || o_err[0] !== 1'b0 || o_to[0] !== 1'b0) begin
      miss_cnt++;
      $display("FAIL in_order_final: got rspc=%0d err=%b to=%b, expected rspc=4 err=0 to=0",
               o_rspc[0], o_err[0], o_to[0]);
    end
  endtask

  task automatic test_max_outstanding();
    int n;
    apply_reset();
    trig_valid = 1'b1; trig_mask = 5'b01111; intr_req_ready = 1'b1;
    tick();
    trig_valid = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    vec_cnt++;
    if (o_outs[1] !== 5'b00011 || o_pend[1] !== 5'b01100 || o_valid[1] !== 1'b0) begin
      miss_cnt++;
      $display("FAIL max_out_gate: got outs=%b pend=%b valid=%b, expected outs=00011 pend=01100 valid=0",
               o_outs[1], o_pend[1], o_valid[1]);
    end
    intr_rsp_valid = 1'b1; rsp_id = 3'd0;
    tick();
    intr_rsp_valid = 1'b0;
    n = 0;
    while (n < 10 && o_outs[1] !== 5'b00110) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (o_outs[1] !== 5'b00110 || o_pend[1] !== 5'b01000) begin
      miss_cnt++;
      $display("FAIL max_out_release: got outs=%b pend=%b after %0d cycles, expected outs=00110 pend=01000",
               o_outs[1], o_pend[1], n);
    end
  endtask

  task automatic test_coalesce();
    int nhs, nreq, seen, sid;
    apply_reset();
    trig_valid = 1'b1; trig_mask = 5'b00010;
    tick();
    tick();
    trig_valid = 1'b0;
    vec_cnt++;
    if (o_coal[0] !== 32'd1) begin
      miss_cnt++;
      $display("FAIL coalesce_count: got %0d, expected 1", o_coal[0]);
    end
    intr_req_ready = 1'b1;
    nhs = 0;
    for (int c = 0; c < 6; c++) begin
      if (o_valid[0] && intr_req_ready) nhs++;
      tick();
    end
    vec_cnt++;
    if (nhs != 1 || o_outs[0] !== 5'b00010) begin
      miss_cnt++;
      $display("FAIL coalesce_single_issue: got %0d handshakes outs=%b, expected 1 handshake outs=00010", nhs, o_outs[0]);
    end
    trig_valid = 1'b1;
    tick();
    trig_valid = 1'b0;
    nreq = 0;
    for (int c = 0; c < 5; c++) begin
      if (o_valid[0]) nreq++;
      tick();
    end
    vec_cnt++;
    if (o_pend[0] !== 5'b00010 || nreq != 0 || o_coal[0] !== 32'd1) begin
      miss_cnt++;
      $display("FAIL retrigger_hold: got pend=%b reqs=%0d coal=%0d, expected pend=00010 reqs=0 coal=1",
               o_pend[0], nreq, o_coal[0]);
    end
    intr_rsp_valid = 1'b1; rsp_id = 3'd1;
    tick();
    intr_rsp_valid = 1'b0;
    seen = 0; sid = -1;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (o_valid[0]) begin seen = 1; sid = int'(o_id[0]); end
      else tick();
    end
    vec_cnt++;
    if (seen != 1 || sid != 1) begin
      miss_cnt++;
      $display("FAIL retrigger_reissue: got seen=%0d id=%0d, expected seen=1 id=1", seen, sid);
    end
  endtask

  task automatic test_unexpected();
    apply_reset();
    intr_rsp_valid = 1'b1; rsp_id = 3'd3;
    tick();
    intr_rsp_valid = 1'b0;
    vec_cnt++;
    if (o_err[0] !== 1'b1 || o_rspc[0] !== 32'd0) begin
      miss_cnt++;
      $display("FAIL unexpected_idle: got err=%b rspc=%0d, expected err=1 rspc=0", o_err[0], o_rspc[0]);
    end
    status_clr = 1'b1;
    tick();
    vec_cnt++;
    if (o_err[0] !== 1'b0) begin
      miss_cnt++;
      $display("FAIL status_clr: got err=%b, expected 0", o_err[0]);
    end
    intr_rsp_valid = 1'b1; rsp_id = 3'd3;
    tick();
    status_clr = 1'b0;
    vec_cnt++;
    if (o_err[0] !== 1'b0) begin
      miss_cnt++;
      $display("FAIL clear_wins: got err=%b, expected 0", o_err[0]);
    end
    rsp_id = 3'd5;
    tick();
    intr_rsp_valid = 1'b0;
    vec_cnt++;
    if (o_err[1] !== 1'b1 || o_rspc[1] !== 32'd0 || o_outs[1] !== 5'b0) begin
      miss_cnt++;
      $display("FAIL out_of_range: got err=%b rspc=%0d outs=%b, expected err=1 rspc=0 outs=0",
               o_err[1], o_rspc[1], o_outs[1]);
    end
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    vec_cnt++;
    if (o_err[1] !== 1'b0) begin
      miss_cnt++;
      $display("FAIL out_of_range_clr: got err=%b, expected 0", o_err[1]);
    end
  endtask

`ifdef OFS_PLAT_HOST_CHAN_INTR_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    trig_valid = 1'b1; trig_mask = 5'b00001; intr_req_ready = 1'b1;
    tick();
    trig_valid = 1'b0;
    tick(); tick();
    for (int c = 0; c < 20; c++) tick();
    vec_cnt++;
    if (o_to[0] !== 1'b1) begin
      miss_cnt++;
      $display("FAIL timeout_fire: got err_timeout=%b, expected 1", o_to[0]);
    end
    apply_reset();
    trig_valid = 1'b1; trig_mask = 5'b00001; intr_req_ready = 1'b1;
    tick();
    trig_valid = 1'b0;
    tick(); tick();
    for (int c = 0; c < 9; c++) tick();
    intr_rsp_valid = 1'b1; rsp_id = 3'd0;
    tick();
    intr_rsp_valid = 1'b0;
    for (int c = 0; c < 25; c++) tick();
    vec_cnt++;
    if (o_to[0] !== 1'b0) begin
      miss_cnt++;
      $display("FAIL timeout_quiet: got err_timeout=%b, expected 0", o_to[0]);
    end
  endtask
`endif

  task automatic test_random();
    int k, j;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      reset          = ($urandom_range(0, 299) == 0);
      trig_valid     = ($urandom_range(0, 3) == 0);
      trig_mask      = 5'($urandom_range(0, 31));
      status_clr     = ($urandom_range(0, 49) == 0);
      intr_req_ready = ($urandom_range(0, 9) < 7);
      intr_rsp_valid = ($urandom_range(0, 9) < 4);
      rsp_id         = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7) begin
        k = int'($urandom_range(0, 1));
        if (m_outs[k] != 0) begin
          j = int'($urandom_range(0, NN[k] - 1));
          for (int t = 0; t < 8 && ((m_outs[k] >> j) & 1) == 0; t++) j = (j + 1) % NN[k];
          rsp_id = 3'(j);
        end
      end
      tick();
      for (int q = 0; q < 2; q++) begin
        vec_cnt++;
        if (o_valid[q] !== (m_busy[q] != 0) || (m_busy[q] != 0 && o_id[q] !== 3'(m_rid[q]))) begin
          miss_cnt++;
          $display("FAIL rand_req inst%0d cyc%0d: got valid=%b id=%0d, expected valid=%0d id=%0d",
                   q, cyc, o_valid[q], o_id[q], m_busy[q], m_rid[q]);
        end
        vec_cnt++;
        if (o_pend[q] !== 5'(m_pend[q]) || o_outs[q] !== 5'(m_outs[q])) begin
          miss_cnt++;
          $display("FAIL rand_sets inst%0d cyc%0d: got pend=%b outs=%b, expected pend=%b outs=%b",
                   q, cyc, o_pend[q], o_outs[q], 5'(m_pend[q]), 5'(m_outs[q]));
        end
        vec_cnt++;
        if (o_rspc[q] !== m_rspc[q] || o_coal[q] !== m_coal[q]) begin
          miss_cnt++;
          $display("FAIL rand_counts inst%0d cyc%0d: got rspc=%0d coal=%0d, expected rspc=%0d coal=%0d",
                   q, cyc, o_rspc[q], o_coal[q], m_rspc[q], m_coal[q]);
        end
        vec_cnt++;
        if (o_err[q] !== m_err[q] || o_to[q] !== m_to[q]) begin
          miss_cnt++;
          $display("FAIL rand_flags inst%0d cyc%0d: got err=%b to=%b, expected err=%b to=%b",
                   q, cyc, o_err[q], o_to[q], m_err[q], m_to[q]);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trig_valid = 1'b0; trig_mask = '0; status_clr = 1'b0;
    intr_req_ready = 1'b0; intr_rsp_valid = 1'b0; rsp_id = '0;
    test_reset();
    test_single();
    test_in_order();
    test_max_outstanding();
    test_coalesce();
    test_unexpected();
`ifdef OFS_PLAT_HOST_CHAN_INTR_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
`default_nettype wire
